// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the single-cycle datapath register file.
//   DATA_W     : width of one register / data word
//   REG_ADDR_W : width of a register index
//   NUM_REGS   : number of architectural registers
//   ZERO_REG   : index of the hardwired-zero register
//   data_word_t: datapath word type, also used by the ALU and the ALU-source
//                mux WIDTH parameter
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef logic [DATA_W-1:0] data_word_t;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of the register file: address decode,
// zero-register and out-of-range masking, and the optional write-to-read
// forwarding mux.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined   : a write in flight to the addressed register is forwarded to
//               rd_data_o in the same cycle, before the clock edge.
//   undefined : no forwarding; the port returns the stored value only.
//
// Ports:
//   rst_i      in   asynchronous reset; forces rd_data_o to 0
//   rd_addr_i  in   register index to read
//   regs_i     in   current contents of the storage array
//   wr_en_i    in   write enable of the shared write port
//   wr_addr_i  in   destination index of the shared write port
//   wr_data_i  in   data of the shared write port
//   rd_data_o  out  read result
// ---------------------------------------------------------------------------
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = NUM_REGS
) (
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [WIDTH-1:0]  regs_i [DEPTH],
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic addr_valid;

    assign addr_valid = (rd_addr_i != ADDR_W'(ZERO_REG)) &&
                        ({1'b0, rd_addr_i} < DEPTH_L);

`ifdef REGFILE_BYPASS_EN
    // Forward only writes that will actually land in the array; a write to
    // r0 or past the end is dropped, so it must not be visible here either.
    logic bypass_hit;

    assign bypass_hit = wr_en_i && addr_valid && (wr_addr_i == rd_addr_i);

    always_comb begin
        rd_data_o = '0;
        if (rst_i) begin
            rd_data_o = '0;
        end else if (bypass_hit) begin
            rd_data_o = wr_data_i;
        end else if (addr_valid) begin
            rd_data_o = regs_i[rd_addr_i];
        end
    end
`else
    // Write-port inputs only matter when forwarding is compiled in.
    logic unused_wr_port;

    assign unused_wr_port = ^{wr_en_i, wr_addr_i, wr_data_i};

    always_comb begin
        rd_data_o = '0;
        if (!rst_i && addr_valid) begin
            rd_data_o = regs_i[rd_addr_i];
        end
    end
`endif

endmodule : regfile_read_port

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// DEPTH x WIDTH register file for the single-cycle datapath: two
// combinational read ports, one rising-edge write port, register 0 reads as
// zero. ReadData2 feeds the A input of the ALU-source mux.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN): same-cycle
// write-to-read forwarding on both read ports (see regfile_read_port).
//
// Ports:
//   Clk            in   rising-edge clock
//   Rst            in   asynchronous active-high reset, clears all registers
//   RegWrite       in   write enable
//   WriteRegister  in   destination register index
//   WriteData      in   data to write
//   ReadRegister1  in   read port 1 index
//   ReadRegister2  in   read port 2 index
//   ReadData1      out  contents of ReadRegister1
//   ReadData2      out  contents of ReadRegister2
// ---------------------------------------------------------------------------
module register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = NUM_REGS
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2
);

    localparam int             NUM_RD_PORTS = 2;
    localparam logic [ADDR_W:0] DEPTH_L     = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  regs_q  [DEPTH];
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr [NUM_RD_PORTS];
    logic [WIDTH-1:0]  rd_data [NUM_RD_PORTS];

    // Writes to r0 or beyond the array are silently dropped, which keeps
    // regs_q[0] at its reset value of zero forever.
    assign wr_en = RegWrite &&
                   (WriteRegister != ADDR_W'(ZERO_REG)) &&
                   ({1'b0, WriteRegister} < DEPTH_L);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[WriteRegister] <= WriteData;
        end
    end

    assign rd_addr[0] = ReadRegister1;
    assign rd_addr[1] = ReadRegister2;

    generate
        for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd_port
            regfile_read_port #(
                .WIDTH  (WIDTH),
                .ADDR_W (ADDR_W),
                .DEPTH  (DEPTH)
            ) u_rd_port (
                .rst_i     (Rst),
                .rd_addr_i (rd_addr[gi]),
                .regs_i    (regs_q),
                .wr_en_i   (wr_en),
                .wr_addr_i (WriteRegister),
                .wr_data_i (WriteData),
                .rd_data_o (rd_data[gi])
            );
        end
    endgenerate

    assign ReadData1 = rd_data[0];
    assign ReadData2 = rd_data[1];

endmodule : register_file

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
// Scoreboard bench for register_file: expected read values come from a
// behavioural register model and are queued when a read is presented, then
// popped and compared against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_register_file;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int D  = 32;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          RegWrite;
    logic [AW-1:0] WriteRegister;
    logic [W-1:0]  WriteData;
    logic [AW-1:0] ReadRegister1;
    logic [AW-1:0] ReadRegister2;
    logic [W-1:0]  ReadData1;
    logic [W-1:0]  ReadData2;

    register_file #(
        .WIDTH  (W),
        .ADDR_W (AW),
        .DEPTH  (D)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string        tag;
        bit           port;   // 0 -> ReadData1, 1 -> ReadData2
        logic [W-1:0] exp;
    } sb_entry_t;

    sb_entry_t    sb_q[$];
    logic [W-1:0] model [D];
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check_val(input string tag, input logic [W-1:0] obs,
                             input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_rd(input logic [AW-1:0] a);
        if (a != '0 && int'(a) < D) return model[a];
        return '0;
    endfunction

    task automatic sb_push(input string tag, input bit port, input logic [W-1:0] exp);
        sb_q.push_back('{tag: tag, port: port, exp: exp});
    endtask

    // Pop every queued expectation and compare it with the live outputs.
    task automatic sb_drain();
        sb_entry_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, e.port ? ReadData2 : ReadData1, e.exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge Clk);
        RegWrite      = 1'b1;
        WriteRegister = a;
        WriteData     = d;
        @(posedge Clk);
        if (!Rst && a != '0 && int'(a) < D) model[a] = d;
        #1;
        RegWrite = 1'b0;
        $display("write r%0d <= 0x%08h", a, d);
    endtask

    task automatic read_pair(input string tag, input logic [AW-1:0] a1,
                             input logic [AW-1:0] a2);
        @(negedge Clk);
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        sb_push({tag, "_p1"}, 1'b0, model_rd(a1));
        sb_push({tag, "_p2"}, 1'b1, model_rd(a2));
        #1;
        $display("read  r%0d=0x%08h r%0d=0x%08h", a1, ReadData1, a2, ReadData2);
        sb_drain();
    endtask

    initial begin
        for (int i = 0; i < D; i++) model[i] = '0;

        // Reset held for two edges while a write is presented.
        Rst           = 1'b1;
        RegWrite      = 1'b1;
        WriteRegister = 5'd3;
        WriteData     = 32'hDEADBEEF;
        ReadRegister1 = 5'd3;
        ReadRegister2 = 5'd3;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        sb_push("in_reset_p1", 1'b0, '0);
        sb_push("in_reset_p2", 1'b1, '0);
        #1;
        $display("read  r3 during reset: 0x%08h 0x%08h", ReadData1, ReadData2);
        sb_drain();
        Rst      = 1'b0;
        RegWrite = 1'b0;

        read_pair("post_reset_r3", 5'd3, 5'd3);
        for (int i = 0; i < D; i++) begin
            read_pair("post_reset_all", AW'(i), AW'(D - 1 - i));
        end

        // Basic writes on consecutive edges.
        do_write(5'd5, 32'd1000000);
        do_write(5'd6, 32'd34991);
        read_pair("basic_r5_r6", 5'd5, 5'd6);

        // Zero register ignores writes.
        do_write(5'd0, 32'd50);
        read_pair("zero_reg", 5'd0, 5'd0);

        // Same-cycle read/write collision on r7.
        do_write(5'd7, 32'd10);
        @(negedge Clk);
        RegWrite      = 1'b1;
        WriteRegister = 5'd7;
        WriteData     = 32'd7;
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd6;
`ifdef REGFILE_BYPASS_EN
        sb_push("collide_pre_p1", 1'b0, 32'd7);
`else
        sb_push("collide_pre_p1", 1'b0, model[7]);
`endif
        sb_push("collide_pre_p2", 1'b1, model[6]);
        #1;
        $display("read  r7 before edge: 0x%08h", ReadData1);
        sb_drain();
        @(posedge Clk);
        model[7] = 32'd7;
        #1;
        RegWrite = 1'b0;
        sb_push("collide_post_p1", 1'b0, model[7]);
        #1;
        $display("read  r7 after edge: 0x%08h", ReadData1);
        sb_drain();

        // Asynchronous reset pulse between clock edges.
        @(negedge Clk);
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd6;
        sb_push("pre_async_r5", 1'b0, model[5]);
        #1;
        sb_drain();
        #1;
        Rst = 1'b1;
        for (int i = 0; i < D; i++) model[i] = '0;
        sb_push("async_rst_p1", 1'b0, '0);
        sb_push("async_rst_p2", 1'b1, '0);
        #1;
        $display("read  during async reset pulse: 0x%08h 0x%08h", ReadData1, ReadData2);
        sb_drain();
        Rst = 1'b0;
        read_pair("after_async_r5", 5'd5, 5'd6);

        // RegWrite low for three edges leaves r5 untouched.
        do_write(5'd5, 32'd77);
        @(negedge Clk);
        RegWrite      = 1'b0;
        WriteRegister = 5'd5;
        WriteData     = 32'd5;
        for (int i = 0; i < 3; i++) begin
            read_pair("hold_r5", 5'd5, 5'd5);
        end

        // Random writes with random read-back, model-checked.
        for (int i = 0; i < 24; i++) begin
            do_write(AW'($urandom_range(0, D - 1)), $urandom);
            read_pair("rand", AW'($urandom_range(0, D - 1)), AW'($urandom_range(0, D - 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_register_file

// File: doc/register_file.md
Name: register_file

Overview:
- Multi-port register file for the single-cycle datapath.
- Sits directly upstream of the ALU-source 2:1 mux: ReadData2 feeds the mux's A input, and the sign-extended immediate feeds its B input.
- Two asynchronous read ports and one synchronous write port.
- Register 0 is hardwired to zero.

Parameters:
- WIDTH, 32, data width of each register and of all data ports.
- ADDR_W, 5, width of each register-address port.
- DEPTH, 32, number of registers; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-high reset; clears every register.
- RegWrite  input  1  write enable, sampled on the rising edge of Clk.
- WriteRegister  input  ADDR_W  destination register index.
- WriteData  input  WIDTH  data to write.
- ReadRegister1  input  ADDR_W  read port 1 index.
- ReadRegister2  input  ADDR_W  read port 2 index.
- ReadData1  output  WIDTH  contents of ReadRegister1.
- ReadData2  output  WIDTH  contents of ReadRegister2; drives the ALU-source mux.

Behaviour:
- Storage: DEPTH x WIDTH flip-flop array, reg[0..DEPTH-1].
- Reset: Rst high clears all registers to 0 immediately, independent of Clk. While Rst is high, both ReadData outputs are 0 for every address.
- Reset mid-write: if Rst is high on a rising Clk edge with RegWrite=1, the write is discarded and the array stays 0.
- Reset deassertion: first possible write is the first rising edge after Rst falls.
- Write: on a rising Clk edge with Rst=0, RegWrite=1 and WriteRegister!=0 and WriteRegister<DEPTH, reg[WriteRegister] <= WriteData.
  - Ignored when WriteRegister==0 or WriteRegister>=DEPTH.
  - RegWrite=0 leaves the array unchanged.
- Read: purely combinational, zero-cycle latency.
  - ReadDataN = reg[ReadRegisterN] when 0 < ReadRegisterN < DEPTH; otherwise 0.
  - Register 0 always reads 0, even after an attempted write.
- Write latency: data written at edge k is visible on read ports immediately after edge k (same cycle as the update, one cycle after presentation).
- Same-cycle read/write of one address (bypass disabled): read returns the old value until the edge, then the new value.
- Both read ports may address the same register; the outputs are identical.
- No X on outputs after reset for any in-range or out-of-range address.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. When RegWrite=1, WriteRegister!=0 and ReadRegisterN==WriteRegister, ReadDataN = WriteData combinationally in the same cycle, before the edge. Rst high still forces outputs to 0.
- Undefined: no forwarding; behaviour exactly as in Behaviour above.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W=32, REG_ADDR_W=5, NUM_REGS=32.
  - ZERO_REG=0 constant.
  - A data-word typedef, reused by the ALU and by the mux instance's WIDTH parameter.
- Natural sub-module regfile_read_port:
  - Address decode, zero-register/out-of-range masking, and the optional bypass mux.
  - Instantiated twice, once per read port.
- Write logic and the storage array stay in register_file.

Test Plan:
- Reset: assert Rst for 2 cycles with RegWrite=1, WriteRegister=3, WriteData=0xDEADBEEF; release, read r3 -> 0; every address reads 0.
- Basic write/read: write r5=1000000, then r6=34991 on consecutive edges; set ReadRegister1=5, ReadRegister2=6 -> ReadData1=1000000, ReadData2=34991.
- Zero register: write r0=50, read r0 on both ports -> 0.
- Same-cycle collision: r7 holds 10; present write r7=7 with ReadRegister1=7.
  - Bypass undefined: 10 before the edge, 7 after.
  - REGFILE_BYPASS_EN defined: 7 before the edge.
- Async reset mid-operation: after r5=1000000, pulse Rst between clock edges -> ReadData1 drops to 0 without a Clk edge; r5 stays 0 after release.
- RegWrite=0 hold: present WriteRegister=5, WriteData=5 with RegWrite=0 for 3 edges -> r5 unchanged at its prior value.
